sevenseg_decoder: RTL
=====================

// Module: sevenseg_decoder
// PURPOSE
//  Inverse of the team's hex-to-seven-segment encoder. Samples an active-low 7-bit segment
//  pattern, such as a display bus driven by the CPU's I/O, and waits until it has been stable.
//  It then decodes the pattern back to a 4-bit digit and hands it out on a valid/ready port.
//  Used as an on-chip display monitor and as a self-check path for the pipelined CPU I/O.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive cycles a pattern must hold before it is reported (>=2)
//  CNT_W          8  width of err_count
// PORTS
//  clock        in   1      system clock; all state updates on its rising edge
//  resetn       in   1      synchronous reset, active-low
//  en           in   1      monitor enable; 0 forces IDLE
//  seg_in       in   7      segment pattern, active-low, bit0=a .. bit6=g
//  digit_out    out  4      decoded digit 0-9, or 4'hF for an unrecognised pattern
//  digit_valid  out  1      digit_out/digit_err hold a report not yet taken
//  digit_ready  in   1      consumer accepts the report when digit_valid&&digit_ready at an edge
//  digit_err    out  1      the held report is an unrecognised pattern
//  overrun      out  1      sticky: a report was dropped because the buffer was full
//  err_count    out  CNT_W  count of unrecognised reports, saturating at all-ones
// BEHAVIOUR
//  Reset (resetn=0 at an edge): every register is cleared.
//   - seg_q<=7'h7F, state<=IDLE, cnt<=0, cand<=7'h7F.
//   - digit_out=0, digit_valid=0, digit_err=0, overrun=0, err_count=0.
//  Input stage: seg_q<=seg_in every cycle. The FSM sees only seg_q.
//  Decode table (seg_q -> digit):
//   - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
//   - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
//   - 1111111 = blank, never reported.
//   - Any other pattern -> 4'hF with err=1.
//  FSM (cnt counts consecutive matching cycles):
//   - IDLE: if en && seg_q!=7'h7F -> SETTLE, cand<=seg_q, cnt<=1.
//   - SETTLE, seg_q==7'h7F -> IDLE, cnt<=0.
//   - SETTLE, other seg_q!=cand -> cand<=seg_q, cnt<=1, stay in SETTLE.
//   - SETTLE, seg_q==cand and cnt<STABLE_CYCLES-1 -> cnt<=cnt+1.
//   - SETTLE, seg_q==cand and cnt==STABLE_CYCLES-1 -> emit decode(cand), -> HOLD.
//   - HOLD: stay while seg_q==cand; no re-emission.
//   - HOLD, seg_q==7'h7F -> IDLE.
//   - HOLD, other change -> SETTLE, cand<=seg_q, cnt<=1.
//   - en=0 in any state -> IDLE, cnt<=0 next edge. The output buffer is unaffected.
//  Latency: a pattern present on seg_in before edge E0 and held is emitted at edge E0+STABLE_CYCLES.
//   With the default of 4, digit_valid is high after the 5th edge.
//  Output buffer (one entry):
//   - Emit while !digit_valid: load digit_out/digit_err, digit_valid<=1.
//   - digit_valid&&digit_ready with no emit: digit_valid<=0 (data may stay stale).
//   - Emit in the same cycle as acceptance: new report loaded, digit_valid stays 1.
//   - Emit while digit_valid&&!digit_ready: new report dropped, old kept, overrun<=1 (sticky to reset).
//  err_count increments by 1 on every emitted err report, whether or not the report is dropped.
//   It saturates at 2^CNT_W-1.
//  Glitches shorter than STABLE_CYCLES cycles never produce a report.
//  Blank between two identical digits yields two reports.
//  Reset mid-SETTLE or with a pending report discards everything. No report after reset until a
//   full new STABLE_CYCLES window completes.
// TESTING
//  1. Reset, idle inputs: seg_in=7'h7F, en=1, 20 cycles -> digit_valid=0, overrun=0, err_count=0.
//  2. Stable digit:
//     - seg_in=0010010 held, ready=0 -> digit_valid=1, digit_out=5, digit_err=0 after 5th edge.
//     - Stays valid for 10 cycles; one ready pulse clears it; no re-report while held.
//  3. Glitch reject: seg_in 0000000 for 3 cycles, then 1111111 -> no report.
//     seg_in 0110000 for 4 cycles -> digit_out=3.
//  4. Invalid pattern:
//     - seg_in=0101010 stable -> digit_out=F, digit_err=1, err_count=1.
//     - Blank then repeat -> err_count=2.
//     - With CNT_W=2, five repeats -> err_count=3.
//  5. Overrun / back-to-back, ready=0:
//     - 1 held 5 cycles, then 7 held 5 cycles -> digit_out=1, overrun=1.
//     - ready=1 on the cycle 7 emits -> digit_out=7, valid stays 1, overrun=0.
//  6. Reset and enable:
//     - resetn=0 for one cycle at cnt=2 of digit 9 -> no report until 4 more stable cycles after release.
//     - en=0 mid-SETTLE -> no report; held report survives en=0.

Source files
------------

// File: rtl/sevenseg_decoder.sv
// Seven-segment pattern monitor: registers an active-low segment bus, waits
// for a pattern to hold steady, decodes it back to a digit and offers the
// result on a single-entry valid/ready buffer with overrun and error tracking.
module sevenseg_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit_out,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             digit_err,
    output logic             overrun,
    output logic [CNT_W-1:0] err_count
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ERR_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Returns {err, digit}; unrecognised patterns give err=1 and digit 4'hF.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1000000: res = 5'b0_0000;
            7'b1111001: res = 5'b0_0001;
            7'b0100100: res = 5'b0_0010;
            7'b0110000: res = 5'b0_0011;
            7'b0011001: res = 5'b0_0100;
            7'b0010010: res = 5'b0_0101;
            7'b0000010: res = 5'b0_0110;
            7'b1111000: res = 5'b0_0111;
            7'b0000000: res = 5'b0_1000;
            7'b0010000: res = 5'b0_1001;
            default:    res = 5'b1_1111;
        endcase
        return res;
    endfunction

    logic [6:0]    seg_q_r;
    logic [6:0]    cand_r;
    logic [6:0]    cand_nx_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    state_t        state_r;
    state_t        state_nx_s;
    logic          emit_s;
    logic [4:0]    decoded_s;

    assign decoded_s = decode(cand_r);

    // Input register and stability FSM state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            seg_q_r <= SEG_BLANK;
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            cand_r  <= SEG_BLANK;
        end else begin
            seg_q_r <= seg_in;
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            cand_r  <= cand_nx_s;
        end
    end

    // Next-state logic: track the candidate pattern and count how long it holds.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        cand_nx_s  = cand_r;
        emit_s     = 1'b0;
        if (!en) begin
            state_nx_s = IDLE;
            cnt_nx_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (seg_q_r != SEG_BLANK) begin
                        state_nx_s = SETTLE;
                        cand_nx_s  = seg_q_r;
                        cnt_nx_s   = CNT_ONE;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                SETTLE: begin
                    if (seg_q_r == SEG_BLANK) begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = CNT_ZERO;
                    end else if (seg_q_r != cand_r) begin
                        cand_nx_s = seg_q_r;
                        cnt_nx_s  = CNT_ONE;
                    end else if (cnt_r == CNT_LAST) begin
                        emit_s     = 1'b1;
                        state_nx_s = HOLD;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (seg_q_r == cand_r) begin
                        state_nx_s = HOLD;
                    end else if (seg_q_r == SEG_BLANK) begin
                        state_nx_s = IDLE;
                        cnt_nx_s   = CNT_ZERO;
                    end else begin
                        state_nx_s = SETTLE;
                        cand_nx_s  = seg_q_r;
                        cnt_nx_s   = CNT_ONE;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // Single-entry report buffer, sticky overrun flag and saturating error count.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            digit_out   <= 4'd0;
            digit_err   <= 1'b0;
            digit_valid <= 1'b0;
            overrun     <= 1'b0;
            err_count   <= {CNT_W{1'b0}};
        end else begin
            if (emit_s) begin
                if (!digit_valid || digit_ready) begin
                    digit_out   <= decoded_s[3:0];
                    digit_err   <= decoded_s[4];
                    digit_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (digit_valid && digit_ready) begin
                digit_valid <= 1'b0;
            end
            // Errors are counted at emission, even when the report is dropped.
            if (emit_s && decoded_s[4] && (err_count != ERR_MAX)) begin
                err_count <= err_count + ERR_ONE;
            end
        end
    end

endmodule
